// File: rtl/lsu.sv
// Load/store unit: runs one req/ack bus transaction per memory op, aligning and
// extending load data or lane-replicating store data with byte enables.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_result_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] count;
    logic [1:0]    offset;
    logic [2:0]    width;
    logic          load_op;

    logic          launch;
    logic          finish;
    logic          capture;
    logic [1:0]    err_n;

    logic          op_load;
    logic          illegal;
    logic          misaligned;
    logic [31:0]   wdata_n;
    logic [3:0]    be_n;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_ext;

    // Decode the incoming op; a start with both kinds set is treated as a load.
    always_comb begin
        op_load    = is_load_i;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (op_load) begin
            illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
        end else begin
            illegal = (funct3_i > 3'b010);
        end
        if (funct3_i[1:0] == 2'b01) begin
            misaligned = addr_i[0];
        end else if (funct3_i[1:0] == 2'b10) begin
            misaligned = (addr_i[1:0] != 2'b00);
        end
    end

    always_comb begin
        wdata_n = store_data_i;
        be_n    = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_n = {4{store_data_i[7:0]}};
                be_n    = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                wdata_n = {2{store_data_i[15:0]}};
                be_n    = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_n = store_data_i;
                be_n    = 4'b1111;
            end
        endcase
    end

    // Lane select uses the offset and width captured at launch, not the live inputs.
    always_comb begin
        lane_b   = 8'h00;
        lane_h   = 16'h0000;
        load_ext = mem_rdata_i;
        case (offset)
            2'b00:   lane_b = mem_rdata_i[7:0];
            2'b01:   lane_b = mem_rdata_i[15:8];
            2'b10:   lane_b = mem_rdata_i[23:16];
            default: lane_b = mem_rdata_i[31:24];
        endcase
        lane_h = offset[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (width)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'h000000, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'h0000, lane_h};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        finish  = 1'b0;
        capture = 1'b0;
        err_n   = ERR_OK;
        case (state)
            IDLE: begin
                if (start_i && (is_load_i || is_store_i)) begin
                    if (illegal) begin
                        state_n = DONE;
                        finish  = 1'b1;
                        err_n   = ERR_ILLEGAL;
                    end else if (misaligned) begin
                        state_n = DONE;
                        finish  = 1'b1;
                        err_n   = ERR_MISALIGN;
                    end else begin
                        state_n = BUS;
                        launch  = 1'b1;
                    end
                end
            end
            BUS: begin
                if (mem_ack_i) begin
                    state_n = DONE;
                    finish  = 1'b1;
                    capture = load_op;
                end else if (TIMEOUT_EN && (count == LAST)) begin
                    state_n = DONE;
                    finish  = 1'b1;
                    err_n   = ERR_TIMEOUT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bus-side registers are loaded once at launch and held for the whole request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0000_0000;
            mem_wdata_o <= 32'h0000_0000;
            mem_be_o    <= 4'b0000;
            offset      <= 2'b00;
            width       <= 3'b000;
            load_op     <= 1'b0;
        end else begin
            mem_req_o <= (state_n == BUS);
            if (launch) begin
                mem_we_o    <= ~op_load;
                mem_addr_o  <= {addr_i[31:2], 2'b00};
                mem_wdata_o <= wdata_n;
                mem_be_o    <= op_load ? 4'b1111 : be_n;
                offset      <= addr_i[1:0];
                width       <= funct3_i;
                load_op     <= op_load;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_o        <= 1'b0;
            err_o         <= ERR_OK;
            load_result_o <= 32'h0000_0000;
        end else begin
            done_o <= finish;
            err_o  <= err_n;
            if (capture) begin
                load_result_o <= load_ext;
            end
        end
    end

    // Counts req-high cycles without ack; cleared on every entry to BUS.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (launch) begin
            count <= '0;
        end else if (state == BUS) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected done results are queued at launch and
// popped when the done pulse appears.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] load_result_o;
    logic        done_o;
    logic [1:0]  err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_load = 32'h0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .is_load_i     (is_load),
        .is_store_i    (is_store),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .store_data_i  (store_data),
        .load_result_o (load_result_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit push, input logic [1:0] e, input logic [31:0] r);
        exp_t x;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = d;
        start      = 1'b1;
        if (push) begin
            x.err = e;
            x.res = r;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic get_exp(output exp_t x, output bit ok);
        ok = (sb.size() > 0);
        x.err = 2'b00;
        x.res = 32'h0;
        if (ok) x = sb.pop_front();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b want=0", mem_req_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
        checks++; if (err_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%b want=00", err_o); end
        checks++; if (load_result_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_result got=%h want=0", load_result_o); end
        checks++;
        if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'h0) begin
            failures++;
            $display("[TB] FAIL reset_bus got we=%b be=%b addr=%h wdata=%h want all 0", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_byte();
        exp_t x; bit seen; bit ok;
        last_load = 32'hFFFF_FF80;
        launch(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 2'b00, last_load);
        checks++; if (mem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL lb_req got=%b want=1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL lb_addr got=%h want=100", mem_addr_o); end
        checks++; if (mem_we_o !== 1'b0) begin failures++; $display("[TB] FAIL lb_we got=%b want=0", mem_we_o); end
        checks++; if (mem_be_o !== 4'b1111) begin failures++; $display("[TB] FAIL lb_be got=%b want=1111", mem_be_o); end
        ack_now(32'h8011_2233);
        checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL lb_latency done got=%b want=1", done_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL lb_req_drop got=%b want=0", mem_req_o); end
        wait_done(seen);
        get_exp(x, ok);
        checks++; if (!seen || !ok) begin failures++; $display("[TB] FAIL lb_done seen=%b queued=%b want 1 1", seen, ok); end
        checks++; if (err_o !== x.err) begin failures++; $display("[TB] FAIL lb_err got=%b want=%b", err_o, x.err); end
        checks++; if (load_result_o !== x.res) begin failures++; $display("[TB] FAIL lb_result got=%h want=%h", load_result_o, x.res); end
        @(posedge clk);
        #1;
        checks++; if (done_o !== 1'b0 || err_o !== 2'b00) begin failures++; $display("[TB] FAIL lb_pulse got done=%b err=%b want 0 00", done_o, err_o); end
    endtask

    task automatic test_load_half();
        exp_t x; bit seen; bit ok;
        last_load = 32'h0000_BEEF;
        launch(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 2'b00, last_load);
        ack_now(32'hBEEF_1234);
        wait_done(seen);
        get_exp(x, ok);
        checks++; if (!seen || !ok || load_result_o !== x.res) begin failures++; $display("[TB] FAIL lhu_result got=%h want=%h seen=%b", load_result_o, x.res, seen); end
        @(posedge clk);
        #1;
        last_load = 32'hFFFF_BEEF;
        launch(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 2'b00, last_load);
        mem_rdata = 32'h0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL lh_hold got req=%b addr=%h want 1 100", mem_req_o, mem_addr_o); end
        ack_now(32'hBEEF_1234);
        wait_done(seen);
        get_exp(x, ok);
        checks++; if (!seen || !ok || load_result_o !== x.res || err_o !== x.err) begin failures++; $display("[TB] FAIL lh_result got=%h err=%b want=%h err=%b", load_result_o, err_o, x.res, x.err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        logic [2:0]  f3 [3]  = '{3'b000, 3'b001, 3'b010};
        logic [31:0] a  [3]  = '{32'h101, 32'h102, 32'h10};
        logic [31:0] d  [3]  = '{32'h1234_56A5, 32'h1234_ABCD, 32'hDEAD_BEEF};
        logic [31:0] wa [3]  = '{32'h100, 32'h100, 32'h10};
        logic [31:0] wd [3]  = '{32'hA5A5_A5A5, 32'hABCD_ABCD, 32'hDEAD_BEEF};
        logic [3:0]  be [3]  = '{4'b0010, 4'b1100, 4'b1111};
        exp_t x; bit seen; bit ok;
        for (int i = 0; i < 3; i++) begin
            launch(1'b0, 1'b1, f3[i], a[i], d[i], 1'b1, 2'b00, last_load);
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== wa[i] || mem_wdata_o !== wd[i] || mem_be_o !== be[i]) begin
                failures++;
                $display("[TB] FAIL store%0d_bus got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 %h %h %b",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, wa[i], wd[i], be[i]);
            end
            ack_now(32'hFFFF_FFFF);
            wait_done(seen);
            get_exp(x, ok);
            checks++;
            if (!seen || !ok || err_o !== x.err || load_result_o !== x.res) begin
                failures++;
                $display("[TB] FAIL store%0d_done seen=%b err=%b result=%h want err=%b result=%h", i, seen, err_o, load_result_o, x.err, x.res);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_errors();
        logic        ld [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [6] = '{3'b010, 3'b011, 3'b110, 3'b100, 3'b001, 3'b101};
        logic [31:0] a  [6] = '{32'h102, 32'h100, 32'h100, 32'h100, 32'h101, 32'h103};
        logic [1:0]  e  [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
        exp_t x; bit ok; bit any;
        for (int i = 0; i < 6; i++) begin
            launch(ld[i], ~ld[i], f3[i], a[i], 32'h5555_5555, 1'b1, e[i], last_load);
            get_exp(x, ok);
            checks++;
            if (!ok || done_o !== 1'b1 || mem_req_o !== 1'b0 || err_o !== x.err || load_result_o !== x.res) begin
                failures++;
                $display("[TB] FAIL err%0d got done=%b req=%b err=%b result=%h want 1 0 %b %h",
                         i, done_o, mem_req_o, err_o, load_result_o, x.err, x.res);
            end
            @(posedge clk);
            #1;
        end
        any = 1'b0;
        launch(1'b0, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 2'b00, 32'h0);
        repeat (3) begin
            if (done_o !== 1'b0 || mem_req_o !== 1'b0) any = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (any) begin failures++; $display("[TB] FAIL no_kind_start got activity=1 want=0"); end
    endtask

    task automatic test_timeout();
        exp_t x; bit ok; int n; bit any;
        launch(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 2'b10, last_load);
        n = 0;
        while (mem_req_o === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++; if (n != 4) begin failures++; $display("[TB] FAIL timeout_req_cycles got=%0d want=4", n); end
        get_exp(x, ok);
        checks++;
        if (!ok || done_o !== 1'b1 || err_o !== x.err || load_result_o !== x.res) begin
            failures++;
            $display("[TB] FAIL timeout_done got done=%b err=%b result=%h want 1 %b %h", done_o, err_o, load_result_o, x.err, x.res);
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        any = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_o !== 1'b0 || load_result_o !== last_load) any = 1'b1;
        end
        mem_ack = 1'b0;
        checks++; if (any) begin failures++; $display("[TB] FAIL idle_ack_ignored got activity=1 want=0"); end
    endtask

    task automatic test_back_to_back();
        exp_t x; bit seen; bit ok; bit any;
        last_load = 32'h1122_3344;
        launch(1'b1, 1'b1, 3'b010, 32'h20, 32'h55, 1'b1, 2'b00, last_load);
        checks++; if (mem_we_o !== 1'b0 || mem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL both_kinds got we=%b req=%b want 0 1", mem_we_o, mem_req_o); end
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h301;
        @(posedge clk);
        #1;
        start = 1'b0; is_store = 1'b0;
        checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h20) begin failures++; $display("[TB] FAIL bus_start_ignored got we=%b addr=%h want 0 20", mem_we_o, mem_addr_o); end
        ack_now(32'h1122_3344);
        wait_done(seen);
        get_exp(x, ok);
        checks++; if (!seen || !ok || load_result_o !== x.res) begin failures++; $display("[TB] FAIL b2b_first got=%h want=%h", load_result_o, x.res); end
        @(posedge clk);
        #1;
        launch(1'b0, 1'b1, 3'b010, 32'h24, 32'hCAFE_0001, 1'b1, 2'b00, last_load);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h24) begin failures++; $display("[TB] FAIL b2b_second_req got req=%b addr=%h want 1 24", mem_req_o, mem_addr_o); end
        ack_now(32'h0);
        wait_done(seen);
        get_exp(x, ok);
        checks++; if (!seen || !ok || err_o !== x.err) begin failures++; $display("[TB] FAIL b2b_second_done seen=%b err=%b want 1 %b", seen, err_o, x.err); end
        any = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_o !== 1'b0) any = 1'b1;
        end
        checks++; if (any) begin failures++; $display("[TB] FAIL b2b_extra_done got=1 want=0"); end
    endtask

    task automatic test_reset_mid();
        exp_t x; bit seen; bit ok; bit any;
        launch(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 1'b0, 2'b00, 32'h0);
        #1;
        rst_n = 1'b0;
        last_load = 32'h0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || done_o !== 1'b0 || load_result_o !== 32'h0 || mem_addr_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset got req=%b done=%b result=%h addr=%h want 0 0 0 0", mem_req_o, done_o, load_result_o, mem_addr_o);
        end
        any = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done_o !== 1'b0 || mem_req_o !== 1'b0) any = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (done_o !== 1'b0) any = 1'b1;
        checks++; if (any) begin failures++; $display("[TB] FAIL reset_no_done got activity=1 want=0"); end
        last_load = 32'hCAFE_F00D;
        launch(1'b1, 1'b0, 3'b010, 32'h84, 32'h0, 1'b1, 2'b00, last_load);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h84) begin failures++; $display("[TB] FAIL fresh_req got req=%b addr=%h want 1 84", mem_req_o, mem_addr_o); end
        ack_now(32'hCAFE_F00D);
        wait_done(seen);
        get_exp(x, ok);
        checks++;
        if (!seen || !ok || err_o !== x.err || load_result_o !== x.res) begin
            failures++;
            $display("[TB] FAIL fresh_lw seen=%b err=%b result=%h want err=%b result=%h", seen, err_o, load_result_o, x.err, x.res);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
